// File: rtl/debounce_pkg.sv
// Shared helpers for debounced input blocks.
// Counter-width function and a wide counter type for constant sizing.
package debounce_pkg;

    localparam int CntMaxW = 32;

    typedef logic [CntMaxW-1:0] debounce_cnt_t;

    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Pin-side bundle of the debounce bank.
// clear/sticky exist only with DEBOUNCE_BANK_STICKY_EN.
interface debounce_bank_if #(
    parameter int Channels = 8
);
    logic [Channels-1:0] pins;
    logic [Channels-1:0] level;
    logic [Channels-1:0] rise;
    logic [Channels-1:0] fall;
    logic                any;
`ifdef DEBOUNCE_BANK_STICKY_EN
    logic [Channels-1:0] clear;
    logic [Channels-1:0] sticky;
`endif

    modport master (
        output pins,
`ifdef DEBOUNCE_BANK_STICKY_EN
        output clear,
        input  sticky,
`endif
        input  level,
        input  rise,
        input  fall,
        input  any
    );

    modport slave (
        input  pins,
`ifdef DEBOUNCE_BANK_STICKY_EN
        input  clear,
        output sticky,
`endif
        output level,
        output rise,
        output fall,
        output any
    );
endinterface

// File: rtl/debounce_channel.sv
// One debounce lane: synchroniser, stability counter,
// level register and registered edge pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int TimeOut    = 1000,
    parameter int SyncStages = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic a,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int W = cnt_width(TimeOut);
    localparam debounce_cnt_t Last = debounce_cnt_t'(TimeOut - 1);

    logic [SyncStages-1:0] sync;
    logic [W-1:0]          cnt;
    logic                  s;

    assign s = sync[SyncStages-1];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[SyncStages-2:0], a};
            rise <= 1'b0;
            fall <= 1'b0;
            // any agreeing cycle restarts the stability count
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == Last[W-1:0]) begin
                level <= s;
                cnt   <= '0;
                rise  <= s;
                fall  <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/debounce_bank.sv
// Multi-channel contact debouncer with level, edge and any outputs.
// Define DEBOUNCE_BANK_STICKY_EN for latched rise events (clear/sticky).
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int                  Channels   = 8,
    parameter int                  TimeOut    = 1000,
    parameter int                  SyncStages = 2,
    parameter logic [Channels-1:0] Inverted   = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    debounce_bank_if.slave   bus
);
    logic [Channels-1:0] a;
    logic [Channels-1:0] lvl;
    logic [Channels-1:0] rs;
    logic [Channels-1:0] fl;

    assign a = bus.pins ^ Inverted;

    for (genvar i = 0; i < Channels; i++) begin : g_ch
        debounce_channel #(
            .TimeOut    (TimeOut),
            .SyncStages (SyncStages)
        ) u_ch (
            .clock   (clock),
            .reset_n (reset_n),
            .a       (a[i]),
            .level   (lvl[i]),
            .rise    (rs[i]),
            .fall    (fl[i])
        );
    end

    assign bus.level = lvl;
    assign bus.rise  = rs;
    assign bus.fall  = fl;
    assign bus.any   = |lvl;

`ifdef DEBOUNCE_BANK_STICKY_EN
    logic [Channels-1:0] sticky_q;

    // set wins over clear so a coincident event is kept
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (sticky_q & ~bus.clear) | rs;
        end
    end

    assign bus.sticky = sticky_q;
`endif
endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank (4 ch, TimeOut 8, 2 sync stages).
// Sticky steps run when DEBOUNCE_BANK_STICKY_EN is defined.
module tb_debounce_bank;
    logic clock;
    logic reset_n;
    int   total;
    int   bad;

    debounce_bank_if #(.Channels(4)) bus ();

    debounce_bank #(
        .Channels   (4),
        .TimeOut    (8),
        .SyncStages (2),
        .Inverted   (4'b0010)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        bus.pins = 4'b1111;
`ifdef DEBOUNCE_BANK_STICKY_EN
        bus.clear = 4'b0000;
`endif
        // 1: reset with all pins high, then release
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("rst_level", bus.level, 4'b0000);
            chk("rst_rise", bus.rise, 4'b0000);
            chk("rst_fall", bus.fall, 4'b0000);
            chk("rst_any", {3'b0, bus.any}, 4'b0000);
        end
        reset_n = 1'b1;
        for (int k = 1; k < 10; k++) begin
            tick(1);
            chk("t1_wait", bus.level, 4'b0000);
        end
        tick(1);
        chk("t1_level", bus.level, 4'b1101);
        chk("t1_rise", bus.rise, 4'b1101);
        chk("t1_fall", bus.fall, 4'b0000);
        chk("t1_any", {3'b0, bus.any}, 4'b0001);
        tick(1);
        chk("t1_rise_end", bus.rise, 4'b0000);

        // 2: bring ch0 low, then chatter, then settle high
        bus.pins = 4'b1110;
        tick(10);
        chk("t2_low", bus.level, 4'b1100);
        chk("t2_fall", bus.fall, 4'b0001);
        for (int k = 0; k < 30; k++) begin
            bus.pins[0] = ((k / 3) % 2 == 0);
            tick(1);
            chk("t2_chatter", bus.level, 4'b1100);
            chk("t2_norise", bus.rise, 4'b0000);
        end
        bus.pins[0] = 1'b1;
        for (int k = 1; k < 10; k++) begin
            tick(1);
            chk("t2_wait", bus.level, 4'b1100);
        end
        tick(1);
        chk("t2_level", bus.level, 4'b1101);
        chk("t2_rise", bus.rise, 4'b0001);
        tick(1);
        chk("t2_rise_end", bus.rise, 4'b0000);

        // 3: 7-cycle glitch is absorbed, 8-cycle pulse flips
        bus.pins[2] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 7) bus.pins[2] = 1'b1;
            tick(1);
            chk("t3_short", bus.level, 4'b1101);
            chk("t3_nofall", bus.fall, 4'b0000);
        end
        bus.pins[2] = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (k == 9) bus.pins[2] = 1'b1;
            tick(1);
            chk("t3_wait", bus.level, 4'b1101);
        end
        bus.pins[2] = 1'b1;
        tick(1);
        chk("t3_level", bus.level, 4'b1001);
        chk("t3_fall", bus.fall, 4'b0100);
        chk("t3_rise", bus.rise, 4'b0000);
        tick(1);
        chk("t3_fall_end", bus.fall, 4'b0000);
        tick(7);
        chk("t3_back", bus.level, 4'b1101);
        chk("t3_back_rise", bus.rise, 4'b0100);

        // 4: all idle, then inverted ch1 goes active
        bus.pins = 4'b0010;
        tick(10);
        chk("t4_idle", bus.level, 4'b0000);
        chk("t4_fall", bus.fall, 4'b1101);
        chk("t4_any0", {3'b0, bus.any}, 4'b0000);
        bus.pins = 4'b0000;
        for (int k = 1; k < 10; k++) begin
            tick(1);
            chk("t4_wait_any", {3'b0, bus.any}, 4'b0000);
        end
        tick(1);
        chk("t4_level", bus.level, 4'b0010);
        chk("t4_rise", bus.rise, 4'b0010);
        chk("t4_any1", {3'b0, bus.any}, 4'b0001);

        // 5: reset mid-count on ch3 discards the partial count
        bus.pins = 4'b1000;
        tick(7);
        chk("t5_mid", bus.level, 4'b0010);
        reset_n = 1'b0;
        tick(1);
        chk("t5_rst", bus.level, 4'b0000);
        chk("t5_rst_any", {3'b0, bus.any}, 4'b0000);
        reset_n = 1'b1;
        for (int k = 1; k < 10; k++) begin
            tick(1);
            chk("t5_wait", bus.level, 4'b0000);
        end
        tick(1);
        chk("t5_level", bus.level, 4'b1010);
        chk("t5_rise", bus.rise, 4'b1010);

        // 6: sticky set/clear, coincident rise and clear keeps the bit
        bus.pins = 4'b1001;
        tick(1);
`ifdef DEBOUNCE_BANK_STICKY_EN
        chk("t6_set", bus.sticky, 4'b1010);
        bus.clear = 4'b0010;
`endif
        tick(1);
`ifdef DEBOUNCE_BANK_STICKY_EN
        chk("t6_clr1", bus.sticky, 4'b1000);
        bus.clear = 4'b0000;
`endif
        tick(8);
        chk("t6_rise0", bus.rise, 4'b0001);
        chk("t6_level", bus.level, 4'b1011);
`ifdef DEBOUNCE_BANK_STICKY_EN
        bus.clear = 4'b0001;
        tick(1);
        chk("t6_both", bus.sticky, 4'b1001);
        tick(1);
        chk("t6_clr0", bus.sticky, 4'b1000);
        bus.clear = 4'b0000;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
